// File: rtl/tone_sequencer.sv
// Arbitrates the shared square-wave tone generator among alarm, timer-expiry and key-click
// requesters, producing timed on/off beep patterns from a tick prescaler.
module tone_sequencer #(
    parameter int TICK_DIV    = 1000000,
    parameter int ALARM_ON    = 20,
    parameter int ALARM_OFF   = 10,
    parameter int TIMER_ON    = 30,
    parameter int TIMER_OFF   = 15,
    parameter int TIMER_BEEPS = 2,
    parameter int KEY_ON      = 3,
    parameter int CW          = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic alarm_act,
    input  logic timer_req,
    input  logic key_req,
    input  logic mute,
    output logic snd_en,
    output logic sw1_o,
    output logic sw2_o,
    output logic busy,
    output logic done
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] LAST_BEEP = CW'(TIMER_BEEPS - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        TONE,
        GAP
    } state_t;

    typedef enum logic [1:0] {
        SRC_ALARM,
        SRC_TIMER,
        SRC_KEY
    } src_t;

    state_t        state, state_n;
    src_t          src, src_n, start_src;
    logic [CW-1:0] dur_cnt, dur_n;
    logic [CW-1:0] beep_cnt, beep_n;
    logic [PW-1:0] presc, presc_n;
    logic          pend_timer, pend_timer_n;
    logic          pend_key, pend_key_n;
    logic          done_q, done_n;
    logic          sw1_q, sw1_n;
    logic          sw2_q, sw2_n;
    logic          start;
    logic          tick;
    logic          seg_end;

    function automatic logic [CW-1:0] on_len(input src_t s);
        case (s)
            SRC_ALARM: on_len = CW'(ALARM_ON);
            SRC_TIMER: on_len = CW'(TIMER_ON);
            default:   on_len = CW'(KEY_ON);
        endcase
    endfunction

    function automatic logic [CW-1:0] off_len(input src_t s);
        case (s)
            SRC_ALARM: off_len = CW'(ALARM_OFF);
            default:   off_len = CW'(TIMER_OFF);
        endcase
    endfunction

    assign tick    = (state != IDLE) && (presc == TICK_LAST);
    assign seg_end = tick && (dur_cnt == ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            src        <= SRC_ALARM;
            dur_cnt    <= '0;
            beep_cnt   <= '0;
            presc      <= '0;
            pend_timer <= 1'b0;
            pend_key   <= 1'b0;
            done_q     <= 1'b0;
            sw1_q      <= 1'b0;
            sw2_q      <= 1'b0;
        end else begin
            state      <= state_n;
            src        <= src_n;
            dur_cnt    <= dur_n;
            beep_cnt   <= beep_n;
            presc      <= presc_n;
            pend_timer <= pend_timer_n;
            pend_key   <= pend_key_n;
            done_q     <= done_n;
            sw1_q      <= sw1_n;
            sw2_q      <= sw2_n;
        end
    end

    always_comb begin
        state_n      = state;
        src_n        = src;
        dur_n        = dur_cnt;
        beep_n       = beep_cnt;
        presc_n      = (state == IDLE || tick) ? '0 : presc + 1'b1;
        pend_timer_n = pend_timer | timer_req;
        pend_key_n   = pend_key | key_req;
        done_n       = 1'b0;
        sw1_n        = sw1_q;
        sw2_n        = sw2_q;
        start        = 1'b0;
        start_src    = SRC_KEY;

        if (state != IDLE && tick && dur_cnt > ONE) begin
            dur_n = dur_cnt - 1'b1;
        end

        case (state)
            IDLE: begin
                if (alarm_act) begin
                    start     = 1'b1;
                    start_src = SRC_ALARM;
                end else if (pend_timer) begin
                    start        = 1'b1;
                    start_src    = SRC_TIMER;
                    pend_timer_n = 1'b0;
                    beep_n       = '0;
                end else if (pend_key) begin
                    start      = 1'b1;
                    start_src  = SRC_KEY;
                    pend_key_n = 1'b0;
                end
            end
            TONE, GAP: begin
                // An alarm preempts any other pattern; an interrupted timer is queued again.
                if (src != SRC_ALARM && alarm_act) begin
                    start     = 1'b1;
                    start_src = SRC_ALARM;
                    if (src == SRC_TIMER) begin
                        pend_timer_n = 1'b1;
                    end
                end else if (src == SRC_ALARM && !alarm_act) begin
                    state_n = IDLE;
                end else if (seg_end) begin
                    if (state == TONE) begin
                        if (src == SRC_KEY || (src == SRC_TIMER && beep_cnt == LAST_BEEP)) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = GAP;
                            dur_n   = off_len(src);
                            presc_n = '0;
                        end
                    end else begin
                        if (src == SRC_TIMER) begin
                            beep_n = beep_cnt + 1'b1;
                        end
                        start     = 1'b1;
                        start_src = src;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (start) begin
            state_n = TONE;
            src_n   = start_src;
            dur_n   = on_len(start_src);
            presc_n = '0;
            sw1_n   = (start_src == SRC_TIMER);
            sw2_n   = (start_src == SRC_ALARM);
        end

        if (mute) begin
            state_n      = IDLE;
            pend_timer_n = 1'b0;
            pend_key_n   = 1'b0;
            done_n       = 1'b0;
        end

        // Selects are released whenever the generator goes quiet between patterns.
        if (state_n == IDLE) begin
            sw1_n   = 1'b0;
            sw2_n   = 1'b0;
            dur_n   = '0;
            presc_n = '0;
        end
    end

    assign snd_en = (state == TONE);
    assign busy   = (state != IDLE);
    assign sw1_o  = sw1_q;
    assign sw2_o  = sw2_q;
    assign done   = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Checks tone_sequencer against a pattern-timeline model: each pattern is tracked only by its
// source and elapsed cycles, with on/off derived from tick arithmetic.
module tb_tone_sequencer;

    localparam int TICK_DIV    = 4;
    localparam int ALARM_ON    = 2;
    localparam int ALARM_OFF   = 1;
    localparam int TIMER_ON    = 3;
    localparam int TIMER_OFF   = 2;
    localparam int TIMER_BEEPS = 2;
    localparam int KEY_ON      = 3;
    localparam int CW          = 8;

    localparam int SA = 0;
    localparam int ST = 1;
    localparam int SK = 2;

    logic clk;
    logic reset;
    logic alarm_act;
    logic timer_req;
    logic key_req;
    logic mute;
    logic snd_en;
    logic sw1_o;
    logic sw2_o;
    logic busy;
    logic done;

    int n_checks;
    int n_fail;
    int cyc;

    bit m_active;
    int m_src;
    int m_el;
    bit m_pt;
    bit m_pk;
    bit m_done;
    bit m_rst;

    bit alarm_l;
    bit mute_l;

    tone_sequencer #(
        .TICK_DIV(TICK_DIV), .ALARM_ON(ALARM_ON), .ALARM_OFF(ALARM_OFF),
        .TIMER_ON(TIMER_ON), .TIMER_OFF(TIMER_OFF), .TIMER_BEEPS(TIMER_BEEPS),
        .KEY_ON(KEY_ON), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .alarm_act(alarm_act), .timer_req(timer_req),
        .key_req(key_req), .mute(mute), .snd_en(snd_en), .sw1_o(sw1_o),
        .sw2_o(sw2_o), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int totalLen(input int s);
        if (s == ST) return (TIMER_BEEPS * TIMER_ON + (TIMER_BEEPS - 1) * TIMER_OFF) * TICK_DIV;
        return KEY_ON * TICK_DIV;
    endfunction

    function automatic bit toneOn(input int s, input int e);
        int t;
        t = e / TICK_DIV;
        if (s == SA) return (t % (ALARM_ON + ALARM_OFF)) < ALARM_ON;
        if (s == ST) return (t % (TIMER_ON + TIMER_OFF)) < TIMER_ON;
        return 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b expected %b at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic checkAll();
        checkOutput("snd_en", snd_en, m_active && toneOn(m_src, m_el));
        checkOutput("busy", busy, m_active);
        checkOutput("done", done, m_done);
        checkOutput("sel_excl", sw1_o & sw2_o, 1'b0);
        if (m_active) begin
            checkOutput("sw1", sw1_o, m_src == ST);
            checkOutput("sw2", sw2_o, m_src == SA);
        end
        if (m_rst) begin
            checkOutput("rst_sw1", sw1_o, 1'b0);
            checkOutput("rst_sw2", sw2_o, 1'b0);
        end
    endtask

    task automatic modelStep();
        bit npt, npk, ndone;
        cyc++;
        m_rst = reset;
        if (reset) begin
            m_active = 0; m_pt = 0; m_pk = 0; m_done = 0; m_el = 0; m_src = SA;
            return;
        end
        npt = m_pt | timer_req;
        npk = m_pk | key_req;
        ndone = 0;
        if (m_active) begin
            if (m_src != SA && alarm_act) begin
                if (m_src == ST) npt = 1;
                m_src = SA; m_el = 0;
            end else if (m_src == SA && !alarm_act) begin
                m_active = 0;
            end else begin
                m_el++;
                if (m_src != SA && m_el == totalLen(m_src)) begin
                    m_active = 0; ndone = 1;
                end
            end
        end else begin
            if (alarm_act) begin
                m_active = 1; m_src = SA; m_el = 0;
            end else if (m_pt) begin
                m_active = 1; m_src = ST; m_el = 0; npt = 0;
            end else if (m_pk) begin
                m_active = 1; m_src = SK; m_el = 0; npk = 0;
            end
        end
        if (mute) begin
            m_active = 0; npt = 0; npk = 0; ndone = 0;
        end
        m_pt = npt; m_pk = npk; m_done = ndone;
    endtask

    // One clock: check last cycle's outputs, drive new inputs, advance the model at the edge.
    task automatic applyStimulus(input logic r, input logic a, input logic t, input logic k, input logic m);
        @(negedge clk);
        checkAll();
        reset = r; alarm_act = a; timer_req = t; key_req = k; mute = m;
        @(posedge clk);
        modelStep();
    endtask

    task automatic idleFor(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        m_active = 0; m_src = SA; m_el = 0; m_pt = 0; m_pk = 0; m_done = 0; m_rst = 0;
        reset = 1'b1; alarm_act = 1'b0; timer_req = 1'b0; key_req = 1'b0; mute = 1'b0;
        @(posedge clk);
        modelStep();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idleFor(5);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idleFor(20);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idleFor(40);

        for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idleFor(5);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idleFor(15);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idleFor(45);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idleFor(60);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idleFor(3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idleFor(6);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idleFor(40);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idleFor(16);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idleFor(10);

        alarm_l = 0; mute_l = 0;
        for (int i = 0; i < 4000; i++) begin
            if (alarm_l) begin
                if ($urandom_range(0, 39) == 0) alarm_l = 0;
            end else if ($urandom_range(0, 149) == 0) alarm_l = 1;
            if (mute_l) begin
                if ($urandom_range(0, 7) == 0) mute_l = 0;
            end else if ($urandom_range(0, 199) == 0) mute_l = 1;
            applyStimulus(($urandom_range(0, 799) == 0), alarm_l,
                          ($urandom_range(0, 24) == 0), ($urandom_range(0, 14) == 0), mute_l);
        end

        @(negedge clk);
        checkAll();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
